// File: rtl/rob_v2.sv
// Reorder buffer: in-order retire of up to N_WAY entries per cycle, with a
// backward squash walk (RECOVER) after a retiring branch redirects fetch.
module rob_v2 #(
   parameter int unsigned N_ENTRIES = 32,
   parameter int unsigned N_WAY     = 2,
   parameter int unsigned TAG_BITS  = 6,
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ZERO_TAG  = 0
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [N_WAY-1:0]                dis_valid,
   input  logic [N_WAY*TAG_BITS-1:0]       dis_tag,
   input  logic [N_WAY*TAG_BITS-1:0]       dis_told,
   input  logic [N_WAY-1:0]                dis_branch,
   output logic [$clog2(N_WAY):0]          dis_credit,
   output logic [N_WAY-1:0]                dis_accepted,
   input  logic [N_WAY-1:0]                cmp_valid,
   input  logic [N_WAY*TAG_BITS-1:0]       cmp_tag,
   input  logic [N_WAY-1:0]                cmp_take_branch,
   input  logic [N_WAY*XLEN-1:0]           cmp_target,
   output logic [N_WAY-1:0]                ret_valid,
   output logic [N_WAY*TAG_BITS-1:0]       ret_tag,
   output logic [N_WAY*TAG_BITS-1:0]       ret_told,
   output logic [N_WAY-1:0]                ret_free,
   output logic                            br_redirect,
   output logic [XLEN-1:0]                 br_target,
   output logic [N_WAY-1:0]                sq_valid,
   output logic [N_WAY*TAG_BITS-1:0]       sq_tag,
   output logic                            recover_busy,
   output logic [$clog2(N_ENTRIES):0]      rob_count
);

   localparam int unsigned PW = $clog2(N_ENTRIES);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned DW = $clog2(N_WAY) + 1;
   localparam logic [TAG_BITS-1:0] ZT = TAG_BITS'(ZERO_TAG);
   localparam logic ST_NORMAL  = 1'b0;
   localparam logic ST_RECOVER = 1'b1;

   logic                ent_valid  [N_ENTRIES];
   logic [TAG_BITS-1:0] ent_tag    [N_ENTRIES];
   logic [TAG_BITS-1:0] ent_told   [N_ENTRIES];
   logic                ent_branch [N_ENTRIES];
   logic                ent_done   [N_ENTRIES];
   logic                ent_take   [N_ENTRIES];
   logic [XLEN-1:0]     ent_target [N_ENTRIES];

   logic [PW-1:0]    head, tail, rd_idx;
   logic [PW-1:0]    wr_idx [N_WAY];
   logic [CW-1:0]    count, count_nxt, free_slots;
   logic             state, state_nxt, stop;
   logic [DW-1:0]    ret_n, sq_n, acc_n;
   logic [N_WAY-1:0] sq_take;

   assign rob_count = count;

   // Retire scan from head stops at the first incomplete entry or after a redirecting branch.
   always_comb begin
      ret_valid   = '0;
      ret_tag     = '0;
      ret_told    = '0;
      ret_free    = '0;
      br_redirect = 1'b0;
      br_target   = '0;
      ret_n       = '0;
      stop        = 1'b0;
      sq_valid    = '0;
      sq_tag      = '0;
      sq_take     = '0;
      sq_n        = '0;
      rd_idx      = '0;
      if (reset_n && state == ST_NORMAL) begin
         for (int unsigned i = 0; i < N_WAY; i++) begin
            rd_idx = head + PW'(i);
            if (!stop && CW'(i) < count && ent_done[rd_idx]) begin
               ret_valid[i]                      = 1'b1;
               ret_tag[i*TAG_BITS +: TAG_BITS]   = ent_tag[rd_idx];
               ret_told[i*TAG_BITS +: TAG_BITS]  = ent_told[rd_idx];
               ret_free[i]                       = ent_told[rd_idx] != ZT;
               ret_n                             = ret_n + DW'(1);
               if (ent_branch[rd_idx] && ent_take[rd_idx]) begin
                  br_redirect = 1'b1;
                  br_target   = ent_target[rd_idx];
                  stop        = 1'b1;
               end
            end else begin
               stop = 1'b1;
            end
         end
      end
      if (reset_n && state == ST_RECOVER) begin
         for (int unsigned i = 0; i < N_WAY; i++) begin
            rd_idx = tail - PW'(i + 1);
            if (CW'(i) < count) begin
               sq_take[i]                      = 1'b1;
               sq_valid[i]                     = ent_tag[rd_idx] != ZT;
               sq_tag[i*TAG_BITS +: TAG_BITS]  = ent_tag[rd_idx];
               sq_n                            = sq_n + DW'(1);
            end
         end
      end
   end

   always_comb begin
      free_slots = CW'(N_ENTRIES) - count;
      if (!reset_n)
         dis_credit = DW'(N_WAY);
      else if (state != ST_NORMAL || br_redirect)
         dis_credit = '0;
      else if (free_slots < CW'(N_WAY))
         dis_credit = free_slots[DW-1:0];
      else
         dis_credit = DW'(N_WAY);
      dis_accepted = '0;
      acc_n        = '0;
      for (int unsigned k = 0; k < N_WAY; k++) begin
         wr_idx[k] = tail + PW'(acc_n);
         if (reset_n && dis_valid[k] && DW'(k) < dis_credit) begin
            dis_accepted[k] = 1'b1;
            acc_n           = acc_n + DW'(1);
         end
      end
      count_nxt = count + CW'(acc_n) - CW'(ret_n) - CW'(sq_n);
      state_nxt = state;
      if (state == ST_NORMAL && br_redirect && count != CW'(ret_n))
         state_nxt = ST_RECOVER;
      else if (state == ST_RECOVER && count == CW'(sq_n))
         state_nxt = ST_NORMAL;
      recover_busy = reset_n && state == ST_RECOVER;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= ST_NORMAL;
         for (int unsigned e = 0; e < N_ENTRIES; e++) begin
            ent_valid[e]  <= 1'b0;
            ent_tag[e]    <= '0;
            ent_told[e]   <= '0;
            ent_branch[e] <= 1'b0;
            ent_done[e]   <= 1'b0;
            ent_take[e]   <= 1'b0;
            ent_target[e] <= '0;
         end
      end else begin
         if (state == ST_NORMAL && !br_redirect) begin
            for (int unsigned e = 0; e < N_ENTRIES; e++) begin
               for (int unsigned i = 0; i < N_WAY; i++) begin
                  if (ent_valid[e] && cmp_valid[i] &&
                      cmp_tag[i*TAG_BITS +: TAG_BITS] != ZT &&
                      cmp_tag[i*TAG_BITS +: TAG_BITS] == ent_tag[e]) begin
                     ent_done[e] <= 1'b1;
                     if (ent_branch[e]) begin
                        ent_take[e]   <= cmp_take_branch[i];
                        ent_target[e] <= cmp_target[i*XLEN +: XLEN];
                     end
                  end
               end
            end
         end
         for (int unsigned i = 0; i < N_WAY; i++) begin
            if (ret_valid[i]) begin
               ent_valid[head + PW'(i)] <= 1'b0;
               ent_done[head + PW'(i)]  <= 1'b0;
               ent_take[head + PW'(i)]  <= 1'b0;
            end
            if (sq_take[i]) begin
               ent_valid[tail - PW'(i + 1)] <= 1'b0;
               ent_done[tail - PW'(i + 1)]  <= 1'b0;
               ent_take[tail - PW'(i + 1)]  <= 1'b0;
            end
         end
         for (int unsigned k = 0; k < N_WAY; k++) begin
            if (dis_accepted[k]) begin
               ent_valid[wr_idx[k]]  <= 1'b1;
               ent_tag[wr_idx[k]]    <= dis_tag[k*TAG_BITS +: TAG_BITS];
               ent_told[wr_idx[k]]   <= dis_told[k*TAG_BITS +: TAG_BITS];
               ent_branch[wr_idx[k]] <= dis_branch[k];
               ent_done[wr_idx[k]]   <= 1'b0;
               ent_take[wr_idx[k]]   <= 1'b0;
               ent_target[wr_idx[k]] <= '0;
            end
         end
         head  <= head + PW'(ret_n);
         tail  <= tail + PW'(acc_n) - PW'(sq_n);
         count <= count_nxt;
         state <= state_nxt;
      end
   end

endmodule

// File: tb/tb_rob_v2.sv
// Bench for rob_v2: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the reorder buffer.
module tb_rob_v2;
   localparam int NE = 8;
   localparam int NW = 2;
   localparam int TB = 6;
   localparam int XL = 32;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [NW-1:0]     dis_valid, dis_branch, cmp_valid, cmp_take_branch;
   logic [NW*TB-1:0]  dis_tag, dis_told, cmp_tag;
   logic [NW*XL-1:0]  cmp_target;
   logic [1:0]        dis_credit;
   logic [NW-1:0]     dis_accepted, ret_valid, ret_free, sq_valid;
   logic [NW*TB-1:0]  ret_tag, ret_told, sq_tag;
   logic              br_redirect, recover_busy;
   logic [XL-1:0]     br_target;
   logic [3:0]        rob_count;

   rob_v2 #(.N_ENTRIES(NE), .N_WAY(NW), .TAG_BITS(TB), .XLEN(XL), .ZERO_TAG(0)) dut (
      .clock(clock), .reset_n(reset_n),
      .dis_valid(dis_valid), .dis_tag(dis_tag), .dis_told(dis_told), .dis_branch(dis_branch),
      .dis_credit(dis_credit), .dis_accepted(dis_accepted),
      .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_take_branch(cmp_take_branch),
      .cmp_target(cmp_target),
      .ret_valid(ret_valid), .ret_tag(ret_tag), .ret_told(ret_told), .ret_free(ret_free),
      .br_redirect(br_redirect), .br_target(br_target),
      .sq_valid(sq_valid), .sq_tag(sq_tag), .recover_busy(recover_busy), .rob_count(rob_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [TB-1:0] tag;
      logic [TB-1:0] told;
      bit            br;
      bit            done;
      bit            take;
      logic [XL-1:0] tgt;
   } ent_t;

   ent_t q[$];
   bit   recov = 0;
   bit   known = 0;
   int   total = 0;
   int   bad   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      dis_valid = '0;
      dis_branch = '0;
      cmp_valid = '0;
      cmp_take_branch = '0;
   endtask

   task automatic dis(input int lane, input logic [TB-1:0] t, input logic [TB-1:0] told, input bit br);
      dis_valid[lane] = 1'b1;
      dis_tag[lane*TB +: TB] = t;
      dis_told[lane*TB +: TB] = told;
      dis_branch[lane] = br;
   endtask

   task automatic cmp(input int lane, input logic [TB-1:0] t, input bit take, input logic [XL-1:0] tgt);
      cmp_valid[lane] = 1'b1;
      cmp_tag[lane*TB +: TB] = t;
      cmp_take_branch[lane] = take;
      cmp_target[lane*XL +: XL] = tgt;
   endtask

   function automatic logic [TB-1:0] fresh(input logic [TB-1:0] avoid);
      logic [TB-1:0] t;
      bit hit;
      t = 1;
      for (int n = 0; n < 500; n++) begin
         t = TB'($urandom_range(63, 1));
         hit = (t == avoid);
         foreach (q[j]) if (q[j].tag == t) hit = 1;
         if (!hit) return t;
      end
      return t;
   endfunction

   // Issue up to two completions for distinct incomplete entries.
   task automatic pick_cmp(input bit always_pick, input bit allow_take);
      int cand[$];
      int used;
      int j;
      used = -1;
      for (int l = 0; l < NW; l++) begin
         if (!always_pick && $urandom_range(1) == 0) continue;
         cand.delete();
         foreach (q[k]) if (!q[k].done && k != used) cand.push_back(k);
         if (cand.size() == 0) continue;
         j = cand[$urandom_range(cand.size() - 1)];
         cmp(l, q[j].tag, allow_take && q[j].br && ($urandom_range(2) == 0), $urandom);
         used = j;
      end
   endtask

   // One clock: compare outputs with the model, advance the model, cross the edge.
   task automatic step();
      int nret, nsq, credit;
      bit redir;
      logic [XL-1:0] tgt;
      logic [NW-1:0] exp_rv, exp_free, exp_acc, exp_sqv;
      logic [TB-1:0] ct;
      ent_t e;
      nret = 0; nsq = 0; redir = 0; tgt = '0;
      exp_rv = '0; exp_free = '0; exp_acc = '0; exp_sqv = '0;
      #1;
      if (reset_n && !recov) begin
         while (nret < NW && nret < q.size() && q[nret].done) begin
            exp_rv[nret] = 1'b1;
            exp_free[nret] = q[nret].told != 0;
            if (q[nret].br && q[nret].take) begin
               redir = 1;
               tgt = q[nret].tgt;
               nret++;
               break;
            end
            nret++;
         end
      end
      if (!reset_n) credit = NW;
      else if (recov || redir) credit = 0;
      else credit = (NE - q.size() < NW) ? NE - q.size() : NW;
      for (int k = 0; k < NW; k++) exp_acc[k] = reset_n && dis_valid[k] && k < credit;
      if (reset_n && recov) nsq = (q.size() < NW) ? q.size() : NW;
      for (int i = 0; i < nsq; i++) exp_sqv[i] = q[q.size() - 1 - i].tag != 0;

      check_eq("dis_credit", dis_credit, credit);
      check_eq("dis_accepted", dis_accepted, exp_acc);
      check_eq("ret_valid", ret_valid, exp_rv);
      check_eq("ret_free", ret_free, exp_free);
      for (int i = 0; i < nret; i++) begin
         check_eq("ret_tag", ret_tag[i*TB +: TB], q[i].tag);
         check_eq("ret_told", ret_told[i*TB +: TB], q[i].told);
      end
      check_eq("br_redirect", br_redirect, redir);
      check_eq("br_target", br_target, tgt);
      check_eq("sq_valid", sq_valid, exp_sqv);
      for (int i = 0; i < nsq; i++)
         if (exp_sqv[i]) check_eq("sq_tag", sq_tag[i*TB +: TB], q[q.size() - 1 - i].tag);
      check_eq("recover_busy", recover_busy, reset_n && recov);
      if (known) check_eq("rob_count", rob_count, q.size());

      if (!reset_n) begin
         q.delete();
         recov = 0;
         known = 1;
      end else begin
         if (!recov && !redir) begin
            for (int i = 0; i < NW; i++) begin
               ct = cmp_tag[i*TB +: TB];
               if (cmp_valid[i] && ct != 0)
                  foreach (q[j]) if (q[j].tag == ct) begin
                     q[j].done = 1;
                     if (q[j].br) begin
                        q[j].take = cmp_take_branch[i];
                        q[j].tgt = cmp_target[i*XL +: XL];
                     end
                  end
            end
         end
         repeat (nret) void'(q.pop_front());
         repeat (nsq) void'(q.pop_back());
         for (int k = 0; k < NW; k++) if (exp_acc[k]) begin
            e.tag = dis_tag[k*TB +: TB];
            e.told = dis_told[k*TB +: TB];
            e.br = dis_branch[k];
            e.done = 0;
            e.take = 0;
            e.tgt = '0;
            q.push_back(e);
         end
         if (!recov && redir) recov = q.size() != 0;
         else if (recov && q.size() == 0) recov = 0;
      end
      @(posedge clock);
      #1;
      idle_inputs();
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (q.size() > 0 || recov); i++) begin
         if (!recov) pick_cmp(1, 0);
         step();
      end
      check_eq("drained", rob_count, 0);
   endtask

   initial begin
      logic [TB-1:0] t0, t1;
      int n;
      idle_inputs();
      dis_tag = '0; dis_told = '0; cmp_tag = '0; cmp_target = '0;
      reset_n = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      check_eq("rst_credit", dis_credit, 2);
      check_eq("rst_count", rob_count, 0);
      check_eq("rst_busy", recover_busy, 0);

      // Fill to capacity, then a pair that must be refused.
      for (int c = 0; c < 4; c++) begin
         dis(0, TB'(2*c + 1), (c == 0) ? TB'(0) : TB'(2*c + 11), 0);
         dis(1, TB'(2*c + 2), TB'(2*c + 12), 0);
         step();
      end
      check_eq("full_count", rob_count, 8);
      check_eq("full_credit", dis_credit, 0);
      dis(0, 9, 19, 0); dis(1, 10, 20, 0);
      step();

      // Out-of-order completion, pair retire; tag 1 has told=0.
      cmp(0, 2, 0, 0); step();
      cmp(0, 1, 0, 0); step();
      check_eq("pair_valid", ret_valid, 2'b11);
      check_eq("pair_tags", ret_tag, {6'd2, 6'd1});
      check_eq("pair_told", ret_told, {6'd12, 6'd0});
      check_eq("pair_free", ret_free, 2'b10);
      step();
      check_eq("pair_count", rob_count, 6);
      drain();

      // Mispredict at head with four younger entries.
      dis(0, 1, 11, 1); dis(1, 2, 12, 0); step();
      dis(0, 3, 13, 0); dis(1, 4, 14, 0); step();
      dis(0, 5, 15, 0); step();
      cmp(0, 1, 1, 32'h100); step();
      check_eq("redir_pulse", br_redirect, 1);
      check_eq("redir_target", br_target, 32'h100);
      check_eq("redir_ret", ret_valid, 2'b01);
      check_eq("redir_credit", dis_credit, 0);
      step();
      check_eq("sq1_busy", recover_busy, 1);
      check_eq("sq1_valid", sq_valid, 2'b11);
      check_eq("sq1_tags", sq_tag, {6'd4, 6'd5});
      check_eq("sq1_credit", dis_credit, 0);
      step();
      check_eq("sq2_busy", recover_busy, 1);
      check_eq("sq2_tags", sq_tag, {6'd2, 6'd3});
      check_eq("sq2_credit", dis_credit, 0);
      step();
      check_eq("rec_done_busy", recover_busy, 0);
      check_eq("rec_done_count", rob_count, 0);
      check_eq("rec_done_credit", dis_credit, 2);

      // Pointer wrap: fill 8, retire 6, dispatch 4 more.
      for (int c = 0; c < 4; c++) begin
         dis(0, TB'(2*c + 1), TB'(2*c + 21), 0);
         dis(1, TB'(2*c + 2), TB'(2*c + 22), 0);
         step();
      end
      cmp(0, 1, 0, 0); cmp(1, 2, 0, 0); step();
      cmp(0, 3, 0, 0); cmp(1, 4, 0, 0); step();
      cmp(0, 5, 0, 0); cmp(1, 6, 0, 0); step();
      step();
      check_eq("wrap_count2", rob_count, 2);
      dis(0, 9, 29, 0); dis(1, 10, 30, 0); step();
      dis(0, 11, 31, 0); dis(1, 12, 32, 0); step();
      check_eq("wrap_count6", rob_count, 6);
      drain();

      // Reset in the middle of a squash walk.
      dis(0, 1, 11, 1); dis(1, 2, 12, 0); step();
      dis(0, 3, 13, 0); dis(1, 4, 14, 0); step();
      dis(0, 5, 15, 0); dis(1, 6, 16, 0); step();
      cmp(0, 1, 1, 32'h200); step();
      step();
      check_eq("mid_sq_valid", sq_valid, 2'b11);
      reset_n = 1'b0;
      #1;
      check_eq("rst_sq_valid", sq_valid, 0);
      check_eq("rst_sq_busy", recover_busy, 0);
      step();
      reset_n = 1'b1;
      check_eq("post_rst_count", rob_count, 0);
      check_eq("post_rst_sq", sq_valid, 0);
      check_eq("post_rst_busy", recover_busy, 0);

      // Random traffic.
      for (int c = 0; c < 1500; c++) begin
         reset_n = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
         n = $urandom_range(2);
         t0 = fresh(0);
         t1 = fresh(t0);
         if (n >= 1) dis(0, t0, ($urandom_range(3) == 0) ? TB'(0) : TB'($urandom), $urandom_range(3) == 0);
         if (n == 2) dis(1, t1, ($urandom_range(3) == 0) ? TB'(0) : TB'($urandom), $urandom_range(3) == 0);
         pick_cmp(0, 1);
         step();
      end
      reset_n = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
